// File: rtl/pattern_gen.sv
// pattern_gen: LED frame pattern writer; PATTERN_GEN_BRIGHTNESS_EN adds a brightness scale input
module pattern_gen #(
  parameter int NUM_LEDS      = 72,
  parameter int BYTES_PER_LED = 3,
  parameter int ADDR_WIDTH    = 13,
  parameter int BASE_ADDRESS  = 0,
  parameter int TICK_DIV      = 65536
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [7:0]            color,
`ifdef PATTERN_GEN_BRIGHTNESS_EN
  input  logic [7:0]            brightness,
`endif
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_ready,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int NUM_CHANNELS = NUM_LEDS * BYTES_PER_LED;
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int LW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  localparam int BW = BYTES_PER_LED > 1 ? $clog2(BYTES_PER_LED) : 1;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, WRITE} state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_tick;
  logic [CW-1:0] r_chan;
  logic [LW-1:0] r_led, r_phase;
  logic [BW-1:0] r_byte;
  logic [1:0]    r_mode;
  logic [7:0]    r_color;
  logic [7:0]    w_raw, w_data;
  logic          w_xfer, w_sample, w_last_chan, w_last_byte;

  assign busy        = r_state != IDLE;
  assign w_xfer      = wr_en & wr_ready;
  assign w_last_chan = r_chan == CW'(NUM_CHANNELS - 1);
  assign w_last_byte = r_byte == BW'(BYTES_PER_LED - 1);
  assign w_sample    = r_state != WRITE && w_next == WRITE && r_chan == '0;

  always_comb begin
    w_raw = r_mode == 2'b00 ? r_color :
            r_mode == 2'b01 ? (r_phase[0] ? 8'h00 : r_color) :
            r_mode == 2'b10 ? (r_led == r_phase ? r_color : 8'h00) :
            8'(r_chan) + 8'(r_phase);
  end

`ifdef PATTERN_GEN_BRIGHTNESS_EN
  logic [7:0] r_bright;
  assign w_data = 8'((16'(w_raw) * (16'(r_bright) + 16'd1)) >> 8);
`else
  assign w_data = w_raw;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = enable ? WAIT_TICK : IDLE;
      WAIT_TICK: w_next = !enable ? IDLE : r_tick == TW'(TICK_DIV - 1) ? WRITE : WAIT_TICK;
      WRITE:     w_next = !w_xfer ? WRITE : enable ? WAIT_TICK : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // WRITE spends one cycle loading the output registers before wr_en rises
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      r_tick     <= '0;
      r_chan     <= '0;
      r_byte     <= '0;
      r_led      <= '0;
      r_phase    <= '0;
      r_mode     <= 2'b00;
      r_color    <= '0;
`ifdef PATTERN_GEN_BRIGHTNESS_EN
      r_bright   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      r_tick     <= r_state == WAIT_TICK ? r_tick + TW'(1) : '0;
      if (w_sample) begin
        r_mode  <= mode;
        r_color <= color;
`ifdef PATTERN_GEN_BRIGHTNESS_EN
        r_bright <= brightness;
`endif
      end
      if (r_state == WRITE && !wr_en) begin
        wr_en   <= 1'b1;
        wr_addr <= ADDR_WIDTH'(BASE_ADDRESS) + ADDR_WIDTH'(r_chan);
        wr_data <= w_data;
      end else if (w_xfer) begin
        wr_en  <= 1'b0;
        r_chan <= w_last_chan ? '0 : r_chan + CW'(1);
        r_byte <= w_last_byte ? '0 : r_byte + BW'(1);
        if (w_last_byte) r_led <= r_led == LW'(NUM_LEDS - 1) ? '0 : r_led + LW'(1);
        if (w_last_chan) begin
          frame_done <= 1'b1;
          r_phase    <= r_phase == LW'(NUM_LEDS - 1) ? '0 : r_phase + LW'(1);
        end
      end
      if (w_next == IDLE) begin
        r_chan <= '0;
        r_byte <= '0;
        r_led  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed frame table plus stall, enable-drop and reset sequences
module tb_pattern_gen;
  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        resetn, enable, wr_ready;
  logic [1:0]  mode;
  logic [7:0]  color;
  logic        wr_en, frame_done, busy;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  color;
    logic [47:0] exp;
  } frame_t;
  frame_t tbl[6];

  pattern_gen #(
    .NUM_LEDS(2), .BYTES_PER_LED(3), .ADDR_WIDTH(13), .BASE_ADDRESS(BASE), .TICK_DIV(2)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mode(mode), .color(color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_en(input string nm);
    for (int c = 0; c < 40 && wr_en !== 1'b1; c++) @(negedge clk);
    chk({nm, " wr_en"}, 32'(wr_en), 1);
  endtask

  task automatic xfer(input int ea, input logic [7:0] ed, input logic efd, input string nm);
    for (int c = 0; c < 40 && !(wr_en === 1'b1 && wr_ready === 1'b1); c++) @(negedge clk);
    chk({nm, " xfer"}, 32'(wr_en & wr_ready), 1);
    chk({nm, " addr"}, 32'(wr_addr), 32'(ea));
    chk({nm, " data"}, 32'(wr_data), 32'(ed));
    @(negedge clk);
    chk({nm, " frame_done"}, 32'(frame_done), 32'(efd));
    chk({nm, " wr_en drop"}, 32'(wr_en), 0);
  endtask

  initial begin
    tbl[0] = '{2'b00, 8'h5A, 48'h5A5A5A5A5A5A};
    tbl[1] = '{2'b01, 8'h03, 48'h000000000000};
    tbl[2] = '{2'b01, 8'h03, 48'h030303030303};
    tbl[3] = '{2'b10, 8'hFF, 48'h000000FFFFFF};
    tbl[4] = '{2'b10, 8'hFF, 48'hFFFFFF000000};
    tbl[5] = '{2'b11, 8'h77, 48'h010203040506};
    resetn = 1'b0; enable = 1'b0; mode = 2'b00; color = 8'h00; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset wr_en", 32'(wr_en), 0);
    chk("reset wr_addr", 32'(wr_addr), 0);
    chk("reset wr_data", 32'(wr_data), 0);
    chk("reset frame_done", 32'(frame_done), 0);
    chk("reset busy", 32'(busy), 0);
    resetn = 1'b1; mode = tbl[0].mode; color = tbl[0].color;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("latency wr_en %0d", k), 32'(wr_en), 0);
      chk($sformatf("latency busy %0d", k), 32'(busy), 1);
    end
    @(negedge clk);
    chk("latency wr_en rise", 32'(wr_en), 1);
    for (int f = 0; f < 6; f++) begin
      mode = tbl[f].mode; color = tbl[f].color;
      for (int i = 0; i < 6; i++) begin
        xfer(BASE + i, tbl[f].exp[47-8*i -: 8], i == 5, $sformatf("frame%0d ch%0d", f, i));
        if (i == 0) begin
          mode = ~tbl[f].mode; color = ~tbl[f].color;
        end
      end
    end
    // back-pressure on channel 2
    mode = 2'b00; color = 8'h3C;
    xfer(BASE + 0, 8'h3C, 1'b0, "stall ch0");
    xfer(BASE + 1, 8'h3C, 1'b0, "stall ch1");
    wr_ready = 1'b0;
    wait_en("stall ch2");
    chk("stall addr", 32'(wr_addr), BASE + 2);
    chk("stall data", 32'(wr_data), 32'h3C);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stall hold wr_en %0d", k), 32'(wr_en), 1);
      chk($sformatf("stall hold addr %0d", k), 32'(wr_addr), BASE + 2);
      chk($sformatf("stall hold data %0d", k), 32'(wr_data), 32'h3C);
    end
    wr_ready = 1'b1;
    xfer(BASE + 2, 8'h3C, 1'b0, "stall ch2 done");
    // enable dropped while a write waits
    wr_ready = 1'b0;
    wait_en("drop ch3");
    enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("drop hold wr_en", 32'(wr_en), 1);
    end
    wr_ready = 1'b1;
    xfer(BASE + 3, 8'h3C, 1'b0, "drop ch3 done");
    chk("drop busy", 32'(busy), 0);
    mode = 2'b00; color = 8'h11; enable = 1'b1;
    for (int i = 0; i < 6; i++) xfer(BASE + i, 8'h11, i == 5, $sformatf("restart ch%0d", i));
    // reset in the middle of a chase frame at phase 1
    mode = 2'b10; color = 8'hFF;
    xfer(BASE + 0, 8'h00, 1'b0, "chase p1 ch0");
    wr_ready = 1'b0;
    wait_en("pre-reset ch1");
    resetn = 1'b0;
    #1;
    chk("async rst wr_en", 32'(wr_en), 0);
    chk("async rst wr_addr", 32'(wr_addr), 0);
    chk("async rst wr_data", 32'(wr_data), 0);
    chk("async rst frame_done", 32'(frame_done), 0);
    chk("async rst busy", 32'(busy), 0);
    @(negedge clk);
    resetn = 1'b1; wr_ready = 1'b1;
    xfer(BASE + 0, 8'hFF, 1'b0, "post-reset ch0");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
